// File: rtl/m68k_bus_pkg.sv
// Shared definitions for the 68000 bus-cycle controller: region codes,
// FSM state encoding, counter widths and the per-region wait lookup.
package m68k_bus_pkg;

  localparam int unsigned WCNT_W = 4;
  localparam int unsigned TCNT_W = 8;
  localparam int unsigned ST_W   = 3;
  localparam int unsigned REG_W  = 3;

  localparam logic [2:0] FC_IACK = 3'b111;

  typedef enum logic [REG_W-1:0] {
    REG_ROM  = 3'd0,
    REG_RAM  = 3'd1,
    REG_IO   = 3'd2,
    REG_IACK = 3'd3,
    REG_NONE = 3'd4
  } region_t;

  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_WAIT  = 3'd1;
  localparam logic [ST_W-1:0] ST_ACK   = 3'd2;
  localparam logic [ST_W-1:0] ST_HOLD  = 3'd3;
  localparam logic [ST_W-1:0] ST_FAULT = 3'd4;

  // Wait-state count loaded at cycle start for a decoded region.
  function automatic logic [WCNT_W-1:0] region_wait(
    input logic [REG_W-1:0] region,
    input int unsigned      rom_w,
    input int unsigned      ram_w,
    input int unsigned      io_w
  );
    case (region)
      REG_ROM: return WCNT_W'(rom_w);
      REG_RAM: return WCNT_W'(ram_w);
      REG_IO:  return WCNT_W'(io_w);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/m68k_addr_decode.sv
// Combinational address / function-code decoder.
// Ports: ba     - byte address {adr,1'b0}
//        fc     - CPU function code
//        region - decoded region code (m68k_bus_pkg::region_t values)
module m68k_addr_decode
  import m68k_bus_pkg::*;
#(
  parameter logic [23:0] RAM_BASE = 24'h014000,
  parameter logic [23:0] RAM_TOP  = 24'h01BFFF,
  parameter logic [23:0] IO_BASE  = 24'h800000
) (
  input  logic [23:0]      ba,
  input  logic [2:0]       fc,
  output logic [REG_W-1:0] region
);

  // Interrupt acknowledge overrides the address map.
  always_comb begin
    region = REG_NONE;
    if (fc == FC_IACK) begin
      region = REG_IACK;
    end else if (ba < RAM_BASE) begin
      region = REG_ROM;
    end else if (ba <= RAM_TOP) begin
      region = REG_RAM;
    end else if (ba[23:16] == IO_BASE[23:16]) begin
      region = REG_IO;
    end
  end

endmodule

// File: rtl/m68k_bus_ctrl.sv
// Bus-cycle controller for the 68000 core: decodes each cycle into
// ROM/RAM/IO/IACK, inserts wait states, and drives registered dtackn,
// RAM byte write pulses, autovector vpan and berrn on unmapped or
// stalled cycles.
// Ports: clk, reset_n (async active-low)
//        asn, rwn, udsn, ldsn, adr[23:1], fc  - CPU bus inputs
//        dtackn, berrn, vpan                  - CPU handshake (active low)
//        rom_cs, ram_cs, io_cs                - region selects
//        ram_we_hi, ram_we_lo                 - single-clock RAM write pulses
//        cyc_busy                             - cycle in progress
module m68k_bus_ctrl
  import m68k_bus_pkg::*;
#(
  parameter int unsigned ROM_WAIT     = 1,
  parameter int unsigned RAM_WAIT     = 0,
  parameter int unsigned IO_WAIT      = 3,
  parameter int unsigned BERR_TIMEOUT = 64,
  parameter logic [23:0] RAM_BASE     = 24'h014000,
  parameter logic [23:0] RAM_TOP      = 24'h01BFFF,
  parameter logic [23:0] IO_BASE      = 24'h800000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        asn,
  input  logic        rwn,
  input  logic        udsn,
  input  logic        ldsn,
  input  logic [23:1] adr,
  input  logic [2:0]  fc,
  output logic        dtackn,
  output logic        berrn,
  output logic        vpan,
  output logic        rom_cs,
  output logic        ram_cs,
  output logic        io_cs,
  output logic        ram_we_hi,
  output logic        ram_we_lo,
  output logic        cyc_busy
);

  localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(BERR_TIMEOUT - 1);

  logic [REG_W-1:0]  dec_region_c;
  logic [ST_W-1:0]   state_q, state_d;
  logic [REG_W-1:0]  region_q, region_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic              ds_seen_q, ds_seen_d;
  logic              dtackn_d, berrn_d, vpan_d;
  logic              rom_cs_d, ram_cs_d, io_cs_d;
  logic              we_hi_d, we_lo_d, busy_d;
  logic              ds_low_c;
  logic              cnt_en_c;

  m68k_addr_decode #(
    .RAM_BASE (RAM_BASE),
    .RAM_TOP  (RAM_TOP),
    .IO_BASE  (IO_BASE)
  ) u_decode (
    .ba     ({adr, 1'b0}),
    .fc     (fc),
    .region (dec_region_c)
  );

  assign ds_low_c = ~(udsn & ldsn);
  // Reads count every clock; writes only once a strobe was seen on an
  // earlier edge, so write latency runs from the first data strobe.
  assign cnt_en_c = rwn | (ds_seen_q & ds_low_c);

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      region_q  <= REG_NONE;
      wcnt_q    <= '0;
      tcnt_q    <= '0;
      ds_seen_q <= 1'b0;
      dtackn    <= 1'b1;
      berrn     <= 1'b1;
      vpan      <= 1'b1;
      rom_cs    <= 1'b0;
      ram_cs    <= 1'b0;
      io_cs     <= 1'b0;
      ram_we_hi <= 1'b0;
      ram_we_lo <= 1'b0;
      cyc_busy  <= 1'b0;
    end else begin
      state_q   <= state_d;
      region_q  <= region_d;
      wcnt_q    <= wcnt_d;
      tcnt_q    <= tcnt_d;
      ds_seen_q <= ds_seen_d;
      dtackn    <= dtackn_d;
      berrn     <= berrn_d;
      vpan      <= vpan_d;
      rom_cs    <= rom_cs_d;
      ram_cs    <= ram_cs_d;
      io_cs     <= io_cs_d;
      ram_we_hi <= we_hi_d;
      ram_we_lo <= we_lo_d;
      cyc_busy  <= busy_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    region_d  = region_q;
    wcnt_d    = wcnt_q;
    tcnt_d    = (tcnt_q == TCNT_MAX) ? tcnt_q : tcnt_q + TCNT_W'(1);
    ds_seen_d = ds_seen_q | ds_low_c;
    dtackn_d  = dtackn;
    berrn_d   = berrn;
    vpan_d    = vpan;
    rom_cs_d  = rom_cs;
    ram_cs_d  = ram_cs;
    io_cs_d   = io_cs;
    we_hi_d   = 1'b0;
    we_lo_d   = 1'b0;
    busy_d    = cyc_busy;

    if (asn && (state_q != ST_IDLE)) begin
      // CPU released the bus: end the cycle and drop everything.
      state_d   = ST_IDLE;
      ds_seen_d = 1'b0;
      dtackn_d  = 1'b1;
      berrn_d   = 1'b1;
      vpan_d    = 1'b1;
      rom_cs_d  = 1'b0;
      ram_cs_d  = 1'b0;
      io_cs_d   = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ds_seen_d = 1'b0;
          if (!asn) begin
            region_d  = dec_region_c;
            wcnt_d    = region_wait(dec_region_c, ROM_WAIT, RAM_WAIT, IO_WAIT);
            tcnt_d    = '0;
            ds_seen_d = ds_low_c;
            busy_d    = 1'b1;
            rom_cs_d  = (dec_region_c == REG_ROM);
            ram_cs_d  = (dec_region_c == REG_RAM);
            io_cs_d   = (dec_region_c == REG_IO);
            case (dec_region_c)
              REG_NONE: state_d = ST_FAULT;
              REG_IACK: begin
                state_d = ST_ACK;
                vpan_d  = 1'b0;
              end
              default:  state_d = ST_WAIT;
            endcase
          end
        end

        ST_WAIT: begin
          if (cnt_en_c && ds_low_c && (wcnt_q == '0)) begin
            state_d  = ST_ACK;
            dtackn_d = 1'b0;
            if (!rwn && (region_q == REG_RAM)) begin
              we_hi_d = ~udsn;
              we_lo_d = ~ldsn;
            end
          end else if (tcnt_q == TCNT_MAX) begin
            state_d = ST_FAULT;
            berrn_d = 1'b0;
          end else if (cnt_en_c && (wcnt_q != '0)) begin
            wcnt_d = wcnt_q - WCNT_W'(1);
          end
        end

        ST_ACK: state_d = ST_HOLD;

        ST_HOLD: state_d = ST_HOLD;

        // berrn is timed from cycle start, not from entry into FAULT.
        ST_FAULT: begin
          if (tcnt_q == TCNT_MAX) begin
            berrn_d = 1'b0;
          end
        end

        default: begin
          state_d  = ST_IDLE;
          dtackn_d = 1'b1;
          berrn_d  = 1'b1;
          vpan_d   = 1'b1;
          rom_cs_d = 1'b0;
          ram_cs_d = 1'b0;
          io_cs_d  = 1'b0;
          busy_d   = 1'b0;
        end
      endcase
    end
  end

endmodule
